// File: rtl/pwm_duty_loader_pkg.sv
// pwm_duty_loader_pkg: shared PWM defaults, frame result type and frame-width helper
package pwm_duty_loader_pkg;
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_DUTY_W  = 8;
  localparam int DEF_FRAME_W = $clog2(DEF_NUM_CH) + DEF_DUTY_W;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [1:0] {FR_NONE, FR_OK, FR_ERR} frame_res_e;
  function automatic int frame_w(input int nch, input int dw);
    return $clog2(nch) + dw;
  endfunction
endpackage

// File: rtl/pwm_sync2.sv
// pwm_sync2: multi-flop synchronizer with parameterized reset level
// ports: clk, rst (async active-high), i_d async input, o_q synchronized output
module pwm_sync2
  import pwm_duty_loader_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ff <= {SYNC_STAGES{RST_VAL}};
    else r_ff <= {r_ff[SYNC_STAGES-2:0], i_d};
  assign o_q = r_ff[SYNC_STAGES-1];
endmodule

// File: rtl/pwm_duty_loader.sv
// pwm_duty_loader: serial frame receiver loading shadow duties, applied to active duties at PWM period end
// ports: clk, rst (async active-high); sclk_i/sdi_i/csn_i serial frame input; period_end_i wrap pulse;
//        duty_o active duties (ch0 in LSBs); pending_o shadow-not-applied flags; frame_ok_o/frame_err_o result pulses
module pwm_duty_loader
  import pwm_duty_loader_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DUTY_W = DEF_DUTY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk_i,
  input  logic                     sdi_i,
  input  logic                     csn_i,
  input  logic                     period_end_i,
  output logic [NUM_CH*DUTY_W-1:0] duty_o,
  output logic [NUM_CH-1:0]        pending_o,
  output logic                     frame_ok_o,
  output logic                     frame_err_o
);
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int FRAME_W = frame_w(NUM_CH, DUTY_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  logic              w_sclk, w_sdi, w_csn;
  logic              w_sclk_rise, w_csn_fall, w_csn_rise;
  logic [CH_W-1:0]   w_ch;
  logic [DUTY_W-1:0] w_duty;
  frame_res_e        w_res;
  logic              r_sclk_d, r_csn_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [DUTY_W-1:0] r_shadow [NUM_CH];
  logic [DUTY_W-1:0] r_active [NUM_CH];
  logic [NUM_CH-1:0] r_pending;
  logic              r_frame_ok, r_frame_err;
  // idle levels on reset so that release never produces a spurious edge
  pwm_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .i_d(sclk_i), .o_q(w_sclk));
  pwm_sync2 #(.RST_VAL(1'b0)) u_sync_sdi  (.clk(clk), .rst(rst), .i_d(sdi_i),  .o_q(w_sdi));
  pwm_sync2 #(.RST_VAL(1'b1)) u_sync_csn  (.clk(clk), .rst(rst), .i_d(csn_i),  .o_q(w_csn));
  always_comb begin
    w_sclk_rise = w_sclk & ~r_sclk_d;
    w_csn_fall  = ~w_csn & r_csn_d;
    w_csn_rise  = w_csn & ~r_csn_d;
    w_ch        = r_shift[FRAME_W-1 -: CH_W];
    w_duty      = r_shift[DUTY_W-1:0];
    w_res       = !w_csn_rise ? FR_NONE : (r_cnt == CNT_FULL) ? FR_OK : FR_ERR;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sclk_d    <= 1'b0;
      r_csn_d     <= 1'b1;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_pending   <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_shadow[c] <= '0;
        r_active[c] <= '0;
      end
    end else begin
      r_sclk_d    <= w_sclk;
      r_csn_d     <= w_csn;
      r_frame_ok  <= (w_res == FR_OK);
      r_frame_err <= (w_res == FR_ERR);
      if (w_csn_fall) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_sclk_rise && !w_csn) begin
        r_shift <= {r_shift[FRAME_W-2:0], w_sdi};
        r_cnt   <= (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;
      end
      // period apply reads the old shadow; a coincident commit wins on pending
      for (int c = 0; c < NUM_CH; c++) begin
        if (period_end_i && r_pending[c]) begin
          r_active[c]  <= r_shadow[c];
          r_pending[c] <= 1'b0;
        end
        if (w_res == FR_OK && w_ch == CH_W'(c)) begin
          r_shadow[c]  <= w_duty;
          r_pending[c] <= 1'b1;
        end
      end
    end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_duty
    assign duty_o[g*DUTY_W +: DUTY_W] = r_active[g];
  end
  assign pending_o   = r_pending;
  assign frame_ok_o  = r_frame_ok;
  assign frame_err_o = r_frame_err;
endmodule

// File: tb/tb_pwm_duty_loader.sv
// tb_pwm_duty_loader: directed scoreboard bench for pwm_duty_loader at default parameters
module tb_pwm_duty_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk_i = 1'b0, sdi_i = 1'b0, csn_i = 1'b1, period_end_i = 1'b0;
  logic [31:0] duty_o;
  logic [3:0]  pending_o;
  logic        frame_ok_o, frame_err_o;
  int          checks = 0, errors = 0;
  logic [1:0]  exp_q[$];
  logic [7:0]  m_shadow [4];
  logic [7:0]  m_active [4];
  logic [3:0]  m_pend;
  always #5 clk = ~clk;
  pwm_duty_loader dut (
    .clk(clk), .rst(rst), .sclk_i(sclk_i), .sdi_i(sdi_i), .csn_i(csn_i),
    .period_end_i(period_end_i), .duty_o(duty_o), .pending_o(pending_o),
    .frame_ok_o(frame_ok_o), .frame_err_o(frame_err_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] m_duty();
    logic [31:0] r;
    for (int c = 0; c < 4; c++) r[c*8 +: 8] = m_active[c];
    return r;
  endfunction
  task automatic check_state(input string tag);
    chk({tag, "_duty"}, duty_o, m_duty());
    chk({tag, "_pending"}, {28'd0, pending_o}, {28'd0, m_pend});
  endtask
  task automatic m_clear();
    for (int c = 0; c < 4; c++) begin
      m_shadow[c] = 8'h00;
      m_active[c] = 8'h00;
    end
    m_pend = 4'h0;
  endtask
  task automatic m_apply();
    for (int c = 0; c < 4; c++)
      if (m_pend[c]) begin
        m_active[c] = m_shadow[c];
        m_pend[c]   = 1'b0;
      end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic csn_low();
    @(negedge clk) csn_i = 1'b0;
    cyc(4);
  endtask
  task automatic shift(input logic [15:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi_i = data[i];
      cyc(3);
      sclk_i = 1'b1;
      cyc(3);
      sclk_i = 1'b0;
    end
    cyc(3);
  endtask
  // raise csn, optionally pulsing period_end_i on the commit edge, and update the model
  task automatic csn_high(input logic [15:0] data, input int n, input bit pe);
    int seen;
    bit ok;
    seen = 0;
    ok = (n == 10);
    exp_q.push_back(ok ? 2'b01 : 2'b10);
    @(negedge clk) csn_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if ((frame_ok_o || frame_err_o) && seen == 0) seen = k;
      if (pe && k == 2) period_end_i = 1'b1;
      if (k == 3) period_end_i = 1'b0;
    end
    chk("pulse_latency", seen, 3);
    if (pe) m_apply();
    if (ok) begin
      m_shadow[data[9:8]] = data[7:0];
      m_pend[data[9:8]]   = 1'b1;
    end
    check_state("after_frame");
  endtask
  task automatic frame(input logic [15:0] data, input int n);
    csn_low();
    shift(data, n);
    csn_high(data, n, 1'b0);
  endtask
  task automatic period();
    @(negedge clk) period_end_i = 1'b1;
    @(negedge clk) period_end_i = 1'b0;
    m_apply();
    check_state("after_period");
  endtask
  always @(negedge clk)
    if (frame_ok_o || frame_err_o) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", {30'd0, frame_err_o, frame_ok_o}, 32'd0);
      else chk("pulse_kind", {30'd0, frame_err_o, frame_ok_o}, {30'd0, exp_q.pop_front()});
    end
  initial begin
    m_clear();
    cyc(3);
    chk("rst_duty", duty_o, 32'd0);
    chk("rst_pending", {28'd0, pending_o}, 32'd0);
    chk("rst_flags", {30'd0, frame_err_o, frame_ok_o}, 32'd0);
    @(negedge clk) rst = 1'b0;
    cyc(4);
    check_state("post_rst");
    frame(16'h280, 10);
    period();
    frame(16'h1AB, 9);
    frame(16'h5AB, 11);
    check_state("bad_frames");
    frame(16'h010, 10);
    frame(16'h020, 10);
    chk("ch0_before_boundary", {24'd0, duty_o[7:0]}, 32'd0);
    period();
    chk("ch0_last_wins", {24'd0, duty_o[7:0]}, 32'h20);
    frame(16'h133, 10);
    csn_low();
    shift(16'h144, 10);
    csn_high(16'h144, 10, 1'b1);
    chk("coincide_ch1_old", {24'd0, duty_o[15:8]}, 32'h33);
    chk("coincide_pend1", {31'd0, pending_o[1]}, 32'd1);
    period();
    chk("coincide_ch1_new", {24'd0, duty_o[15:8]}, 32'h44);
    for (int i = 0; i < 12; i++) begin
      sdi_i = 1'($urandom_range(0, 1));
      sclk_i = 1'b1;
      cyc(3);
      sclk_i = 1'b0;
      cyc(3);
    end
    check_state("sclk_csn_high");
    csn_low();
    shift(16'h15, 5);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst_duty", duty_o, 32'd0);
    chk("midrst_pending", {28'd0, pending_o}, 32'd0);
    chk("midrst_flags", {30'd0, frame_err_o, frame_ok_o}, 32'd0);
    csn_i = 1'b1;
    cyc(3);
    rst = 1'b0;
    m_clear();
    cyc(5);
    check_state("midrst_release");
    frame(16'h3FF, 10);
    period();
    chk("ch3_ff", {24'd0, duty_o[31:24]}, 32'hFF);
    csn_low();
    shift(16'h5, 3);
    @(negedge clk) rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    m_clear();
    cyc(4);
    shift(16'hA, 4);
    csn_high(16'hA, 4, 1'b0);
    cyc(4);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
